// File: rtl/dotprod_sequencer_pkg.sv
// Shared definitions for the dot-product accelerator.
// Contents:
//   state_t             - sequencer state encoding (3 bits)
//   ADDR_STRIDE_DEFAULT - byte step between consecutive vector elements
//   DOTP_*              - instruction fields that select the dot-product op;
//                         the CPU control unit decodes with the same constants
//   relu_clamp()        - optional clamp of a negative result to zero
package dotprod_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_A   = 3'd1,
        ST_WAIT_A = 3'd2,
        ST_RD_B   = 3'd3,
        ST_WAIT_B = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    localparam int ADDR_STRIDE_DEFAULT = 4;

    // custom-0 major opcode with a dedicated funct3/funct7 pair
    localparam logic [6:0] DOTP_OPCODE = 7'b0001011;
    localparam logic [2:0] DOTP_FUNCT3 = 3'b001;
    localparam logic [6:0] DOTP_FUNCT7 = 7'b0000101;

    function automatic logic [31:0] relu_clamp(input logic [31:0] value, input logic enable);
        return (enable && value[31]) ? 32'h0 : value;
    endfunction

endpackage

// File: rtl/dotprod_sequencer_mac.sv
// dp_mac: 32x32 signed multiply-accumulate.
// Ports:
//   clk, reset_n - clock, synchronous active-low reset
//   clr          - zero the accumulator (wins over en)
//   en           - add a*b into the accumulator
//   a, b         - signed operands
//   acc          - registered accumulator value
module dp_mac (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] acc
);

    logic [31:0] product;
    logic [31:0] acc_reg;

    // The low 32 bits of a two's-complement product do not depend on
    // signedness, so a 32-bit wide multiply gives the truncated signed result.
    assign product = a * b;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_reg <= 32'h0;
        end else if (clr) begin
            acc_reg <= 32'h0;
        end else if (en) begin
            acc_reg <= acc_reg + product;
        end
    end

    assign acc = acc_reg;

endmodule

// File: rtl/dotprod_sequencer.sv
// dotprod_sequencer: walks two word vectors in data memory, one read at a
// time over a request/grant port, and accumulates the element products.
// Ports:
//   clk, reset_n       - clock, synchronous active-low reset
//   start, base_a, base_b, len, relu_en - command, sampled only in IDLE
//   abort              - cancel a running operation (no done, result kept)
//   busy, stall        - not-idle flag; CPU hold (start | busy)
//   done, result       - one-cycle completion pulse and the 32-bit result
//   mem_req/mem_addr/mem_gnt/mem_rvalid/mem_rdata - shared read port
module dotprod_sequencer
    import dotprod_sequencer_pkg::*;
#(
    parameter int LEN_W       = 16,
    parameter int ADDR_STRIDE = ADDR_STRIDE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [31:0]      base_a,
    input  logic [31:0]      base_b,
    input  logic [LEN_W-1:0] len,
    input  logic             relu_en,
    input  logic             abort,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [31:0]      result,
    output logic             mem_req,
    output logic [31:0]      mem_addr,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata
);

    state_t           state_reg, state_next;
    logic [31:0]      ptr_a_reg, ptr_b_reg;
    logic [31:0]      op_a_reg;
    logic [31:0]      result_reg;
    logic [LEN_W-1:0] remaining_reg;
    logic             relu_reg;

    logic             mac_clr, mac_en;
    logic             last_elem;
    logic [31:0]      acc;
    logic [31:0]      clamped;

    assign last_elem = (remaining_reg == LEN_W'(1));
    assign clamped   = relu_clamp(acc, relu_reg);

    always_comb begin
        state_next = state_reg;
        busy       = 1'b1;
        mem_req    = 1'b0;
        mem_addr   = 32'h0;
        done       = 1'b0;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    mac_clr    = 1'b1;
                    state_next = (len == '0) ? ST_DONE : ST_RD_A;
                end
            end
            ST_RD_A: begin
                mem_req  = 1'b1;
                mem_addr = ptr_a_reg;
                if (mem_gnt) state_next = ST_WAIT_A;
            end
            ST_WAIT_A: begin
                if (mem_rvalid) state_next = ST_RD_B;
            end
            ST_RD_B: begin
                mem_req  = 1'b1;
                mem_addr = ptr_b_reg;
                if (mem_gnt) state_next = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                if (mem_rvalid) begin
                    mac_en     = 1'b1;
                    state_next = last_elem ? ST_DONE : ST_RD_A;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // Abort only redirects the next state; the request stays stable for
        // this cycle so the arbiter never sees it vanish mid-cycle. A read
        // granted now returns while idle and is dropped there.
        if (abort && state_reg != ST_IDLE) begin
            state_next = ST_IDLE;
            done       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            ptr_a_reg     <= 32'h0;
            ptr_b_reg     <= 32'h0;
            op_a_reg      <= 32'h0;
            result_reg    <= 32'h0;
            remaining_reg <= '0;
            relu_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_IDLE && start) begin
                ptr_a_reg     <= base_a;
                ptr_b_reg     <= base_b;
                remaining_reg <= len;
                relu_reg      <= relu_en;
            end
            if (state_reg == ST_WAIT_A && mem_rvalid) begin
                op_a_reg <= mem_rdata;
            end
            if (mac_en) begin
                ptr_a_reg     <= ptr_a_reg + 32'(ADDR_STRIDE);
                ptr_b_reg     <= ptr_b_reg + 32'(ADDR_STRIDE);
                remaining_reg <= remaining_reg - LEN_W'(1);
            end
            if (done) begin
                result_reg <= clamped;
            end
        end
    end

    dp_mac u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (mac_clr),
        .en      (mac_en),
        .a       (op_a_reg),
        .b       (mem_rdata),
        .acc     (acc)
    );

    // The new value is presented during the done pulse itself and held after.
    assign result = done ? clamped : result_reg;
    assign stall  = start | busy;

endmodule

// File: tb/tb_dotprod_sequencer.sv
module tb_dotprod_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] base_a;
    logic [31:0] base_b;
    logic [15:0] len;
    logic        relu_en;
    logic        abort;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] addr_q [$];
    int          gnt_delay = 0;
    bit          noise     = 0;

    dotprod_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .base_a     (base_a),
        .base_b     (base_b),
        .len        (len),
        .relu_en    (relu_en),
        .abort      (abort),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .result     (result),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    // Memory responder: grant after gnt_delay waiting cycles, data the cycle
    // after the grant. With noise on, it also throws stray gnt (no request)
    // and stray rvalid (nothing outstanding) at the DUT.
    initial begin
        bit          pend;
        logic [31:0] pend_addr;
        logic [31:0] hold_addr;
        int          wait_cnt;
        pend = 0; pend_addr = 0; hold_addr = 0; wait_cnt = 0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_gnt    = 1'b0;
            if (pend) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_mem(pend_addr);
                pend       = 0;
            end else if (noise && $urandom_range(0, 3) == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = $urandom;
            end
            if (mem_req === 1'b1) begin
                if (wait_cnt == 0) hold_addr = mem_addr;
                else chk("addr_hold", mem_addr, hold_addr);
                if (wait_cnt >= gnt_delay) begin
                    mem_gnt   = 1'b1;
                    pend      = 1;
                    pend_addr = mem_addr;
                    addr_q.push_back(mem_addr);
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                if (noise) mem_gnt = 1'($urandom_range(0, 1));
            end
        end
    end

    // One complete operation checked against a plain-arithmetic model.
    task automatic run_op(input logic [31:0] ba, input logic [31:0] bb, input int n,
                          input bit relu, input int d, input bit restart, input bit ab0);
        int          acc;
        logic [31:0] exp_res;
        int          exp_lat;
        int          c0;
        int          lat;
        bit          seen;
        acc = 0;
        for (int i = 0; i < n; i++)
            acc += int'(rd_mem(ba + 32'(4 * i))) * int'(rd_mem(bb + 32'(4 * i)));
        exp_res = (relu && acc < 0) ? 32'h0 : 32'(acc);
        exp_lat = (n == 0) ? 1 : n * (2 * d + 4) + 1;
        gnt_delay = d;
        addr_q.delete();
        @(negedge clk);
        base_a = ba; base_b = bb; len = 16'(n); relu_en = relu; abort = ab0; start = 1'b1;
        c0 = cyc;
        #1;
        chk("stall_on_start", 32'(stall), 32'd1);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        seen = 0; lat = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            if (done === 1'b1) begin
                seen = 1;
                lat  = cyc - c0;
            end else begin
                if (restart && k == 1 && exp_lat > 4) begin
                    start = 1'b1; base_a = ~ba; base_b = ~bb; len = 16'(n + 1);
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("result", result, exp_res);
        chk("addr_count", 32'(addr_q.size()), 32'(2 * n));
        for (int i = 0; i < n && 2 * i + 1 < addr_q.size(); i++) begin
            chk("addr_a", addr_q[2 * i], ba + 32'(4 * i));
            chk("addr_b", addr_q[2 * i + 1], bb + 32'(4 * i));
        end
        $display("op len=%0d relu=%0d gnt_delay=%0d -> result %h latency %0d", n, relu, d, result, lat);
        @(negedge clk);
        chk("done_width", 32'(done), 32'd0);
        chk("result_hold", result, exp_res);
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int          c0;
        bit          seen_done;
        logic [31:0] r;
        logic [31:0] ba;
        logic [31:0] bb;
        int          n;

        reset_n = 1'b0; start = 1'b0; abort = 1'b0; relu_en = 1'b0;
        base_a = 32'h0; base_b = 32'h0; len = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_stall", 32'(stall), 32'd0);
        reset_n = 1'b1;

        // A=[1,2,3], B=[4,5,6]
        for (int i = 0; i < 3; i++) begin
            mem[32'h100 + 32'(4 * i)] = 32'(i + 1);
            mem[32'h200 + 32'(4 * i)] = 32'(i + 4);
        end
        run_op(32'h100, 32'h200, 3, 0, 0, 0, 0);

        // A=[-5], B=[7] with and without clamp
        mem[32'h300] = 32'hFFFF_FFFB;
        mem[32'h400] = 32'd7;
        run_op(32'h300, 32'h400, 1, 1, 0, 0, 0);
        run_op(32'h300, 32'h400, 1, 0, 0, 0, 0);

        // empty vector
        run_op(32'h300, 32'h400, 0, 0, 0, 0, 0);

        // grant withheld 3 cycles, A=[2,3], B=[10,10]
        mem[32'h500] = 32'd2;  mem[32'h504] = 32'd3;
        mem[32'h600] = 32'd10; mem[32'h604] = 32'd10;
        run_op(32'h500, 32'h600, 2, 0, 3, 0, 0);

        // abort in WAIT_B of the second element
        for (int i = 0; i < 4; i++) begin
            mem[32'h700 + 32'(4 * i)] = 32'(i + 1);
            mem[32'h800 + 32'(4 * i)] = 32'(i + 1);
        end
        gnt_delay = 0;
        @(negedge clk);
        base_a = 32'h700; base_b = 32'h800; len = 16'd4; relu_en = 1'b0; start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20 && cyc < c0 + 8; k++) @(negedge clk);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        chk("abort_pre_req", 32'(mem_req), 32'd0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_req", 32'(mem_req), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", result, 32'd50);
        seen_done = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        chk("abort_result_kept", result, 32'd50);
        $display("abort: busy %0d result %h", busy, result);
        run_op(32'h700, 32'h800, 4, 0, 0, 0, 0);

        // second start mid-operation, then reset in RD_B
        @(negedge clk);
        base_a = 32'h700; base_b = 32'h800; len = 16'd3; start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; base_a = 32'hDEAD_0000; base_b = 32'hBEEF_0000; len = 16'd9;
        @(negedge clk);
        start = 1'b0;
        chk("rdb_req", 32'(mem_req), 32'd1);
        chk("rdb_addr", mem_addr, 32'h800);
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_addr", mem_addr, 32'h0);
        chk("mid_rst_result", result, 32'h0);
        $display("reset in RD_B: busy %0d req %0d result %h", busy, mem_req, result);
        reset_n = 1'b1;
        @(negedge clk);

        // randomized operations with bus noise; first one wraps the pointers
        noise = 1;
        for (int t = 0; t < 10; t++) begin
            r  = $urandom;
            ba = (t == 0) ? 32'hFFFF_FFF8 : (r & 32'hFFFF_FFFC);
            r  = $urandom;
            bb = r & 32'hFFFF_FFFC;
            n  = (t == 0) ? 4 : $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                mem[ba + 32'(4 * i)] = $urandom;
                mem[bb + 32'(4 * i)] = $urandom;
            end
            run_op(ba, bb, n, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                   1'(t % 2), (t == 3) ? 1'b1 : 1'b0);
        end
        noise = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
